fabric_config_loader: RTL and testbench
=======================================

Name: fabric_config_loader

Overview:
- Serial configuration writer for the 3x3 fabric top.
- Hunts a sync word on a 1-bit configuration stream, then shifts 833 payload bits into a shadow register and checks an 8-bit CRC.
- On a good CRC, commits the payload in one cycle to the parallel config buses the fabric consumes (iostream, cbstream1, cbstreamleft_or_right, clb_mux_sel, bitstream, sbstream).
- The fabric is fed only from committed registers and never sees a partially loaded frame.

Parameters:
- CFG_BITS, 833, payload length in bits (20+300+120+9+144+240).
- SYNC_W, 16, sync word width.
- SYNC_WORD, 16'hA5C3, frame start pattern.
- CRC_W, 8, CRC width.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- reset  input  1  asynchronous, active-high reset.
- cfg_din  input  1  serial config data bit.
- cfg_valid  input  1  cfg_din is sampled only when high.
- restart  input  1  single-cycle pulse: abort or finish, return to HUNT.
- iostream  output  20  committed I/O box config.
- cbstream1  output  300  committed connection-box config.
- cbstreamleft_or_right  output  120  committed connection-box side-select config.
- clb_mux_sel  output  9  committed CLB output-mux select.
- bitstream  output  144  committed CLB LUT contents.
- sbstream  output  240  committed switch-box config.
- cfg_done  output  1  high while in DONE (a valid frame has been committed).
- cfg_error  output  1  high while in ERROR (CRC mismatch).
- busy  output  1  high in LOAD or CRC.

Behaviour:
- Reset is one clock; asynchronous and active-high. Reset forces state HUNT, and clears shadow, sync shifter, bit counter, CRC and all outputs to 0.
- Payload bit order: the first payload bit lands in shadow[832], the last in shadow[0].
- Shadow field map:
  - iostream = shadow[832:813]
  - cbstream1 = shadow[812:513]
  - cbstreamleft_or_right = shadow[512:393]
  - clb_mux_sel = shadow[392:384]
  - bitstream = shadow[383:240]
  - sbstream = shadow[239:0]
- State HUNT:
  - On each valid bit: sync_sr <= {sync_sr[14:0], cfg_din}.
  - If {sync_sr[14:0], cfg_din} == SYNC_WORD, go to LOAD. This clears the bit counter and CRC, and clears sync_sr.
  - Overlapping or partial matches are fine; only an exact 16-bit match triggers.
- State LOAD:
  - On each valid bit: shadow shifts left with cfg_din in at bit 0, counter increments, and the CRC updates.
  - After the valid bit with counter == CFG_BITS-1, go to CRC with the counter cleared.
- CRC algorithm: poly x^8+x^2+x+1 (0x07), init 0x00, MSB-first serial, no reflection, no final XOR.
  - fb = crc[7] ^ cfg_din
  - crc <= {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00)
- State CRC:
  - Shift 8 received CRC bits, MSB first, into rx_crc.
  - On the 8th valid bit, compare {rx_crc[6:0], cfg_din} with the computed CRC.
  - Match: go to DONE, and load all six output buses from shadow at that same edge. Outputs change the cycle after the last CRC bit.
  - Mismatch: go to ERROR; outputs are unchanged.
- DONE and ERROR: hold state and ignore cfg_valid until restart.
- restart:
  - In any state: go to HUNT and clear sync_sr, counter, CRC, cfg_done and cfg_error.
  - Committed output buses are retained, so the previous good configuration stays live.
  - restart has priority over a valid bit in the same cycle.
- cfg_valid low: no state change, no shift, no counter change. Gaps of any length are legal.
- Async reset mid-frame: all outputs go to 0 immediately, without waiting for a clock edge.
- Status output values per state:
  - HUNT: busy=0, done=0, error=0.
  - LOAD and CRC: busy=1.
  - DONE: done=1.
  - ERROR: error=1.

Decomposition:
- Package fabric_cfg_pkg holds:
  - CFG_BITS, SYNC_WORD and CRC_POLY.
  - The field widths and LSB offsets listed above.
  - The state enum {HUNT, LOAD, CRC, DONE, ERROR}.
- One sub-module, crc8_serial, with ports clk, reset, clr, en, din, crc[7:0], implementing the update rule above.

Test Plan:
- Reset: assert reset with random stream -> all buses 0; done=0, error=0, busy=0; state HUNT.
- Good frame: send 0xA5C3, then a payload with only the first bit 1, then the CRC from the reference model -> the cycle after the last CRC bit, done=1, iostream=20'h80000, all other buses 0.
- Bad CRC: repeat with the CRC LSB flipped -> error=1, outputs keep the previous frame's values. Then restart -> HUNT, error=0.
- Near-miss sync: send 0xA5C2 followed by 833 bits -> busy stays 0, no commit.
- Valid gaps: good frame with cfg_valid toggling 1/0 every cycle -> same committed values as the gap-free frame, done asserted one cycle after the last valid CRC bit.
- Abort: restart at payload bit 400, then a full good frame with sbstream=240'h1 -> the old outputs hold during the reload, then sbstream=1, done=1. Async reset at payload bit 500 of a frame -> outputs 0 the same cycle.

Source files
------------

// File: rtl/fabric_cfg_pkg.sv
// Shared constants, field map and state type for the fabric configuration loader.
package fabric_cfg_pkg;

  localparam int unsigned CFG_BITS = 833;
  localparam int unsigned SYNC_W   = 16;
  localparam int unsigned CRC_W    = 8;
  // Wide enough to count every payload bit.
  localparam int unsigned CNT_W    = 10;

  localparam logic [SYNC_W-1:0] SYNC_WORD = 16'hA5C3;
  localparam logic [CRC_W-1:0]  CRC_POLY  = 8'h07;

  // Field widths and LSB offsets inside the shadow register. The first payload bit
  // received ends up in the MSB of the shadow, i.e. the MSB of iostream.
  localparam int unsigned IO_W    = 20;
  localparam int unsigned IO_LSB  = 813;
  localparam int unsigned CB1_W   = 300;
  localparam int unsigned CB1_LSB = 513;
  localparam int unsigned CBLR_W  = 120;
  localparam int unsigned CBLR_LSB = 393;
  localparam int unsigned MUX_W   = 9;
  localparam int unsigned MUX_LSB = 384;
  localparam int unsigned LUT_W   = 144;
  localparam int unsigned LUT_LSB = 240;
  localparam int unsigned SB_W    = 240;
  localparam int unsigned SB_LSB  = 0;

  localparam logic [CNT_W-1:0] LAST_PAYLOAD_CNT = CNT_W'(CFG_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_CRC_CNT     = CNT_W'(CRC_W - 1);

  typedef enum logic [2:0] {HUNT, LOAD, CRC, DONE, ERROR} cfg_state_e;

  // One MSB-first serial step of CRC-8 (poly 0x07, no reflection).
  function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc,
                                                 input logic din);
    logic fb;
    fb = crc[CRC_W-1] ^ din;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 accumulator; clr wins over en.
module crc8_serial
  import fabric_cfg_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [CRC_W-1:0] crc
);

  // CRC register: cleared at frame start, advanced once per payload bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc8_step(crc, din);
    end
  end

endmodule

// File: rtl/fabric_config_loader.sv
// Serial configuration loader: hunts a sync word, shifts a payload into a shadow
// register, checks its CRC and commits it atomically to the fabric config buses.
module fabric_config_loader
  import fabric_cfg_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_din,
  input  logic                cfg_valid,
  input  logic                restart,
  output logic [IO_W-1:0]     iostream,
  output logic [CB1_W-1:0]    cbstream1,
  output logic [CBLR_W-1:0]   cbstreamleft_or_right,
  output logic [MUX_W-1:0]    clb_mux_sel,
  output logic [LUT_W-1:0]    bitstream,
  output logic [SB_W-1:0]     sbstream,
  output logic                cfg_done,
  output logic                cfg_error,
  output logic                busy
);

  cfg_state_e           state_q, state_d;
  // Only the last 15 history bits are kept; the 16th comes straight from cfg_din.
  logic [SYNC_W-2:0]    sync_q, sync_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CRC_W-2:0]     rx_crc_q, rx_crc_d;
  logic [CFG_BITS-1:0]  shadow_q;
  logic [CRC_W-1:0]     crc_val;
  logic                 crc_clr, crc_en, shadow_en, commit;

  crc8_serial u_crc (
    .clk   (clk),
    .reset (reset),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (cfg_din),
    .crc   (crc_val)
  );

  // Next-state logic; restart overrides any valid bit in the same cycle.
  always_comb begin
    state_d   = state_q;
    sync_d    = sync_q;
    cnt_d     = cnt_q;
    rx_crc_d  = rx_crc_q;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    shadow_en = 1'b0;
    commit    = 1'b0;
    if (restart) begin
      state_d = HUNT;
      sync_d  = '0;
      cnt_d   = '0;
      crc_clr = 1'b1;
    end else if (cfg_valid) begin
      unique case (state_q)
        HUNT: begin
          sync_d = {sync_q[SYNC_W-3:0], cfg_din};
          if ({sync_q, cfg_din} == SYNC_WORD) begin
            state_d = LOAD;
            sync_d  = '0;
            cnt_d   = '0;
            crc_clr = 1'b1;
          end
        end
        LOAD: begin
          shadow_en = 1'b1;
          crc_en    = 1'b1;
          if (cnt_q == LAST_PAYLOAD_CNT) begin
            state_d = CRC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        CRC: begin
          rx_crc_d = {rx_crc_q[CRC_W-3:0], cfg_din};
          if (cnt_q == LAST_CRC_CNT) begin
            cnt_d = '0;
            if ({rx_crc_q, cfg_din} == crc_val) begin
              state_d = DONE;
              commit  = 1'b1;
            end else begin
              state_d = ERROR;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE, ERROR: ;
        default: state_d = HUNT;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= HUNT;
      sync_q   <= '0;
      cnt_q    <= '0;
      rx_crc_q <= '0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      rx_crc_q <= rx_crc_d;
    end
  end

  // Shadow register: first payload bit migrates up to the MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
    end else if (shadow_en) begin
      shadow_q <= {shadow_q[CFG_BITS-2:0], cfg_din};
    end
  end

  // Committed buses: updated only on a CRC-good frame, survive restart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iostream              <= '0;
      cbstream1             <= '0;
      cbstreamleft_or_right <= '0;
      clb_mux_sel           <= '0;
      bitstream             <= '0;
      sbstream              <= '0;
    end else if (commit) begin
      iostream              <= shadow_q[IO_LSB +: IO_W];
      cbstream1             <= shadow_q[CB1_LSB +: CB1_W];
      cbstreamleft_or_right <= shadow_q[CBLR_LSB +: CBLR_W];
      clb_mux_sel           <= shadow_q[MUX_LSB +: MUX_W];
      bitstream             <= shadow_q[LUT_LSB +: LUT_W];
      sbstream              <= shadow_q[SB_LSB +: SB_W];
    end
  end

  // Status flags decoded from the current state.
  always_comb begin
    busy      = (state_q == LOAD) || (state_q == CRC);
    cfg_done  = (state_q == DONE);
    cfg_error = (state_q == ERROR);
  end

endmodule

// File: tb/tb_fabric_config_loader.sv
// Randomized self-checking bench for fabric_config_loader.
module tb_fabric_config_loader;
  import fabric_cfg_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cfg_din = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         restart = 1'b0;
  logic [19:0]  iostream;
  logic [299:0] cbstream1;
  logic [119:0] cbstreamleft_or_right;
  logic [8:0]   clb_mux_sel;
  logic [143:0] bitstream;
  logic [239:0] sbstream;
  logic         cfg_done, cfg_error, busy;

  int           chk_cnt = 0;
  int           pass_cnt = 0;
  logic [832:0] exp_cfg = '0;
  logic         busy_seen = 1'b0;

  fabric_config_loader dut (
    .clk                   (clk),
    .reset                 (reset),
    .cfg_din               (cfg_din),
    .cfg_valid             (cfg_valid),
    .restart               (restart),
    .iostream              (iostream),
    .cbstream1             (cbstream1),
    .cbstreamleft_or_right (cbstreamleft_or_right),
    .clb_mux_sel           (clb_mux_sel),
    .bitstream             (bitstream),
    .sbstream              (sbstream),
    .cfg_done              (cfg_done),
    .cfg_error             (cfg_error),
    .busy                  (busy)
  );

  always #5 clk = ~clk;

  // All six buses in field-map order reassemble the 833-bit committed frame.
  function automatic logic [832:0] dut_cfg();
    return {iostream, cbstream1, cbstreamleft_or_right, clb_mux_sel, bitstream, sbstream};
  endfunction

  // Reference CRC as polynomial division: remainder of M(x)*x^8 mod (x^8+x^2+x+1).
  function automatic logic [7:0] ref_crc(input logic [832:0] p);
    logic [8:0] rem;
    logic       b;
    rem = '0;
    for (int i = 0; i < 833 + 8; i++) begin
      b = (i < 833) ? p[832-i] : 1'b0;
      rem = {rem[7:0], b};
      if (rem[8]) rem = rem ^ 9'h107;
    end
    return rem[7:0];
  endfunction

  function automatic logic [832:0] rand_payload();
    logic [832:0] p;
    for (int i = 0; i < 833; i++) p[i] = 1'($urandom_range(0, 1));
    return p;
  endfunction

  // gap_mode: 0 none, 1 one idle cycle before each bit, 2 random 0..2 idle cycles.
  task automatic drive_bit(input logic b, input int gap_mode);
    int gaps;
    gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
    repeat (gaps) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
      cfg_valid = 1'b0;
      cfg_din   = 1'($urandom);
    end
    @(negedge clk);
    if (busy) busy_seen = 1'b1;
    restart   = 1'b0;
    cfg_valid = 1'b1;
    cfg_din   = b;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    restart   = 1'b0;
    cfg_valid = 1'b0;
    cfg_din   = 1'($urandom);
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart   = 1'b1;
    cfg_valid = 1'b0;
    idle_cycle();
  endtask

  task automatic send_word16(input logic [15:0] w, input int gm);
    for (int i = 15; i >= 0; i--) drive_bit(w[i], gm);
  endtask

  task automatic send_payload(input logic [832:0] p, input int from, input int to, input int gm);
    for (int i = from; i < to; i++) drive_bit(p[832-i], gm);
  endtask

  task automatic send_crc(input logic [7:0] c, input int n, input int gm);
    for (int i = 0; i < n; i++) drive_bit(c[7-i], gm);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    cfg_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      cfg_din = 1'($urandom);
    end
    chk_cnt++;
    if (dut_cfg() !== '0) $display("FAIL reset_buses: got %h want 0", dut_cfg());
    else pass_cnt++;
    chk_cnt++;
    if ({cfg_done, cfg_error, busy} !== 3'b000)
      $display("FAIL reset_status: got %b want 000", {cfg_done, cfg_error, busy});
    else pass_cnt++;
    chk_cnt++;
    if (dut.state_q !== HUNT) $display("FAIL reset_state: got %0d want HUNT", dut.state_q);
    else pass_cnt++;
    reset     = 1'b0;
    cfg_valid = 1'b0;
    exp_cfg   = '0;
    idle_cycle();
  endtask

  task automatic test_good_frame();
    logic [832:0] p;
    logic [7:0]   c;
    p = '0;
    p[832] = 1'b1;
    c = ref_crc(p);
    send_word16(SYNC_WORD, 0);
    send_payload(p, 0, 100, 0);
    idle_cycle();
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL good_busy_load: got %b want 1", busy);
    else pass_cnt++;
    send_payload(p, 100, 833, 0);
    send_crc(c, 7, 0);
    idle_cycle();
    chk_cnt++;
    if ({cfg_done, busy} !== 2'b01 || dut_cfg() !== exp_cfg)
      $display("FAIL good_pre_commit: got done,busy=%b want 01", {cfg_done, busy});
    else pass_cnt++;
    drive_bit(c[0], 0);
    idle_cycle();
    chk_cnt++;
    if ({cfg_done, cfg_error, busy} !== 3'b100)
      $display("FAIL good_status: got %b want 100", {cfg_done, cfg_error, busy});
    else pass_cnt++;
    chk_cnt++;
    if (iostream !== 20'h80000) $display("FAIL good_iostream: got %h want 80000", iostream);
    else pass_cnt++;
    chk_cnt++;
    if (dut_cfg() !== p) $display("FAIL good_buses: got %h want %h", dut_cfg(), p);
    else pass_cnt++;
    exp_cfg = p;
  endtask

  task automatic test_bad_crc();
    logic [832:0] p;
    logic [7:0]   c;
    pulse_restart();
    p = rand_payload();
    c = ref_crc(p) ^ 8'h01;
    send_word16(SYNC_WORD, 0);
    send_payload(p, 0, 833, 0);
    send_crc(c, 8, 0);
    idle_cycle();
    chk_cnt++;
    if ({cfg_done, cfg_error, busy} !== 3'b010)
      $display("FAIL bad_status: got %b want 010", {cfg_done, cfg_error, busy});
    else pass_cnt++;
    chk_cnt++;
    if (dut_cfg() !== exp_cfg) $display("FAIL bad_hold: got %h want %h", dut_cfg(), exp_cfg);
    else pass_cnt++;
    pulse_restart();
    chk_cnt++;
    if (cfg_error !== 1'b0 || dut.state_q !== HUNT)
      $display("FAIL bad_restart: got error=%b state=%0d want 0 HUNT", cfg_error, dut.state_q);
    else pass_cnt++;
    chk_cnt++;
    if (dut_cfg() !== exp_cfg) $display("FAIL bad_retain: got %h want %h", dut_cfg(), exp_cfg);
    else pass_cnt++;
  endtask

  task automatic test_near_miss();
    logic [832:0] p;
    logic [15:0]  win;
    logic [15:0]  near;
    bit           hit;
    near = 16'hA5C2;
    do begin
      p   = rand_payload();
      hit = 1'b0;
      win = '0;
      for (int i = 15; i >= 0; i--) begin
        win = {win[14:0], near[i]};
        if (win == SYNC_WORD) hit = 1'b1;
      end
      for (int i = 0; i < 833; i++) begin
        win = {win[14:0], p[832-i]};
        if (win == SYNC_WORD) hit = 1'b1;
      end
    end while (hit);
    pulse_restart();
    busy_seen = 1'b0;
    send_word16(near, 0);
    send_payload(p, 0, 833, 0);
    idle_cycle();
    if (busy) busy_seen = 1'b1;
    chk_cnt++;
    if (busy_seen !== 1'b0) $display("FAIL near_busy: got %b want 0", busy_seen);
    else pass_cnt++;
    chk_cnt++;
    if (cfg_done !== 1'b0 || dut_cfg() !== exp_cfg)
      $display("FAIL near_commit: got done=%b buses %h want 0 %h", cfg_done, dut_cfg(), exp_cfg);
    else pass_cnt++;
  endtask

  task automatic test_valid_gaps(input int gm, input string tag);
    logic [832:0] p;
    logic [7:0]   c;
    pulse_restart();
    p = rand_payload();
    c = ref_crc(p);
    send_word16(SYNC_WORD, gm);
    send_payload(p, 0, 833, gm);
    send_crc(c, 7, gm);
    idle_cycle();
    chk_cnt++;
    if (cfg_done !== 1'b0) $display("FAIL %s_early_done: got %b want 0", tag, cfg_done);
    else pass_cnt++;
    drive_bit(c[0], gm);
    idle_cycle();
    chk_cnt++;
    if (cfg_done !== 1'b1) $display("FAIL %s_done: got %b want 1", tag, cfg_done);
    else pass_cnt++;
    chk_cnt++;
    if (dut_cfg() !== p) $display("FAIL %s_buses: got %h want %h", tag, dut_cfg(), p);
    else pass_cnt++;
    exp_cfg = p;
  endtask

  task automatic test_abort();
    logic [832:0] p;
    logic [7:0]   c;
    pulse_restart();
    p = rand_payload();
    send_word16(SYNC_WORD, 0);
    send_payload(p, 0, 400, 0);
    // restart collides with a valid bit and must win.
    @(negedge clk);
    restart   = 1'b1;
    cfg_valid = 1'b1;
    cfg_din   = 1'($urandom);
    idle_cycle();
    chk_cnt++;
    if (busy !== 1'b0 || dut.state_q !== HUNT || dut_cfg() !== exp_cfg)
      $display("FAIL abort_restart: got busy=%b state=%0d want 0 HUNT", busy, dut.state_q);
    else pass_cnt++;
    p = 833'h1;
    c = ref_crc(p);
    send_word16(SYNC_WORD, 0);
    send_payload(p, 0, 600, 0);
    idle_cycle();
    chk_cnt++;
    if (busy !== 1'b1 || dut_cfg() !== exp_cfg)
      $display("FAIL abort_reload_hold: got busy=%b buses %h want 1 %h", busy, dut_cfg(), exp_cfg);
    else pass_cnt++;
    send_payload(p, 600, 833, 0);
    send_crc(c, 8, 0);
    idle_cycle();
    chk_cnt++;
    if (cfg_done !== 1'b1 || sbstream !== 240'h1)
      $display("FAIL abort_sb: got done=%b sbstream=%h want 1 1", cfg_done, sbstream);
    else pass_cnt++;
    chk_cnt++;
    if (dut_cfg() !== p) $display("FAIL abort_buses: got %h want %h", dut_cfg(), p);
    else pass_cnt++;
    exp_cfg = p;
  endtask

  task automatic test_async_reset();
    logic [832:0] p;
    pulse_restart();
    p = rand_payload();
    send_word16(SYNC_WORD, 0);
    send_payload(p, 0, 500, 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_cnt++;
    if (dut_cfg() !== '0 || busy !== 1'b0 || cfg_done !== 1'b0)
      $display("FAIL async_reset: got buses %h busy=%b want 0 0", dut_cfg(), busy);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    exp_cfg = '0;
    idle_cycle();
    chk_cnt++;
    if (dut.state_q !== HUNT) $display("FAIL async_state: got %0d want HUNT", dut.state_q);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_crc();
    test_near_miss();
    test_valid_gaps(1, "toggle_gaps");
    test_valid_gaps(2, "random_gaps");
    test_valid_gaps(0, "back_to_back");
    test_abort();
    test_async_reset();
    test_valid_gaps(2, "post_reset");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
